// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_pkg
// Desc   : Shared encodings, store-buffer entry layout and drain FSM states.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_responder_pkg;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  localparam int unsigned WORD_IDX_W = 30;

  typedef struct packed {
    logic [WORD_IDX_W-1:0] word_idx;
    logic [3:0]            byte_en;
    logic [31:0]           data;
  } sb_entry_t;

  typedef enum logic [0:0] {
    DRAIN_IDLE = 1'b0,
    DRAIN_BUSY = 1'b1
  } drain_state_e;

  // Unrecognised size codes behave as full-word accesses.
  function automatic logic [3:0] norm_sel(input logic [3:0] sel);
    case (sel)
      SEL_BYTE, SEL_HALF: return sel;
      default:            return SEL_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fwd.sv
`default_nettype none
// ============================================================================
// Module : store_buffer_fwd
// Desc   : In-order circular store buffer with per-lane youngest-match lookup.
// Rev    : 1.0  initial release
// ============================================================================
module store_buffer_fwd
  import dmem_responder_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  localparam int unsigned PTR_W   = $clog2(SB_DEPTH),
  localparam int unsigned CNT_W   = $clog2(SB_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic                  pop,
  output sb_entry_t             head_entry,
  output logic [CNT_W-1:0]      count,
  input  logic [WORD_IDX_W-1:0] lookup_idx,
  output logic [3:0]            fwd_hit,
  output logic [31:0]           fwd_data
);

  sb_entry_t        mem_q [SB_DEPTH];
  sb_entry_t        mem_d [SB_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Walk oldest to youngest so a younger matching lane overrides an older one.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (mem_q[slot].word_idx == lookup_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_q[slot].byte_en[b]) begin
            fwd_hit[b]        = 1'b1;
            fwd_data[8*b +: 8] = mem_q[slot].data[8*b +: 8];
          end
        end
      end
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Desc   : Data-memory responder: combinational loads with store forwarding,
//          buffered stores retired by a wait-state drain FSM.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned SB_DEPTH    = 4,
  parameter int unsigned WR_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Memory_access,
  input  logic        Memory_RW,
  input  logic [3:0]  Memory_sel,
  input  logic [31:0] Memory_Address,
  input  logic [31:0] Memory_Write_Data,
  output logic [31:0] Memory_Read_Data,
  output logic        Memory_Ready,
  output logic        SB_Empty,
  output logic        Overflow_Err,
  output logic        Misaligned_Err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(SB_DEPTH + 1);
  localparam int unsigned WAIT_W = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(WR_LATENCY - 1);

  logic [3:0]            sel_norm;
  logic                  misaligned;
  logic [IDX_W-1:0]      word_idx;
  logic [WORD_IDX_W-1:0] word_idx_ext;
  logic [4:0]            lane_shift;
  logic                  store_req;
  logic                  can_push;
  logic                  push;
  logic                  commit;
  sb_entry_t             push_entry;
  sb_entry_t             head_entry;
  logic [CNT_W-1:0]      sb_count;
  logic [3:0]            fwd_hit;
  logic [31:0]           fwd_data;
  logic [31:0]           arr_word;
  logic [31:0]           merged;
  logic [31:0]           shifted;
  logic [31:0]           load_data;
  logic [IDX_W-1:0]      head_idx;
  logic                  addr_unused;
  logic                  head_unused;

  drain_state_e          state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  overflow_q, overflow_d;
  logic                  mis_err_q, mis_err_d;

  logic [31:0]           dmem_q [DEPTH_WORDS];

  assign sel_norm     = norm_sel(Memory_sel);
  assign misaligned   = ((sel_norm == SEL_HALF) && Memory_Address[0]) ||
                        ((sel_norm == SEL_WORD) && (Memory_Address[1:0] != 2'b00));
  assign word_idx     = Memory_Address[IDX_W+1:2];
  assign word_idx_ext = WORD_IDX_W'(word_idx);
  assign lane_shift   = {Memory_Address[1:0], 3'b000};
  assign addr_unused  = ^Memory_Address[31:IDX_W+2];

  assign store_req = Memory_access && (Memory_RW == RW_STORE) && !misaligned;
  assign commit    = (state_q == DRAIN_BUSY) && (wait_q == '0);
  assign can_push  = (sb_count < CNT_W'(SB_DEPTH)) || commit;
  assign push      = store_req && can_push;

  assign push_entry.word_idx = word_idx_ext;
  assign push_entry.byte_en  = sel_norm << Memory_Address[1:0];
  assign push_entry.data     = Memory_Write_Data << lane_shift;

  store_buffer_fwd #(
    .SB_DEPTH   (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (commit),
    .head_entry (head_entry),
    .count      (sb_count),
    .lookup_idx (word_idx_ext),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  assign head_idx    = head_entry.word_idx[IDX_W-1:0];
  assign head_unused = ^head_entry.word_idx[WORD_IDX_W-1:IDX_W];

  // A reset arriving on the commit edge must not leave a partial write behind.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (head_entry.byte_en[b]) begin
          dmem_q[head_idx][8*b +: 8] <= head_entry.data[8*b +: 8];
        end
      end
    end
  end

  assign arr_word = dmem_q[word_idx];

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign merged[8*b +: 8] = fwd_hit[b] ? fwd_data[8*b +: 8] : arr_word[8*b +: 8];
  end

  assign shifted = merged >> lane_shift;

  always_comb begin
    load_data = 32'h0;
    case (sel_norm)
      SEL_BYTE: load_data = {24'h0, shifted[7:0]};
      SEL_HALF: load_data = {16'h0, shifted[15:0]};
      default:  load_data = shifted;
    endcase
  end

  assign Memory_Read_Data = (Memory_access && (Memory_RW == RW_LOAD) && !misaligned)
                            ? load_data : 32'h0;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      DRAIN_IDLE: begin
        if (sb_count != '0) begin
          state_d = DRAIN_BUSY;
          wait_d  = WAIT_RELOAD;
        end
      end
      DRAIN_BUSY: begin
        if (commit) begin
          if ((sb_count > CNT_W'(1)) || push) begin
            wait_d = WAIT_RELOAD;
          end else begin
            state_d = DRAIN_IDLE;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q || (store_req && !can_push);
    mis_err_d  = Memory_access && misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DRAIN_IDLE;
      wait_q     <= '0;
      overflow_q <= 1'b0;
      mis_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
      mis_err_q  <= mis_err_d;
    end
  end

  assign Memory_Ready   = (sb_count < CNT_W'(SB_DEPTH));
  assign SB_Empty       = (sb_count == '0) && (state_q == DRAIN_IDLE);
  assign Overflow_Err   = overflow_q;
  assign Misaligned_Err = mis_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_responder
// Desc   : Directed self-checking bench for dmem_responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc;
  logic        rw;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sb_empty;
  logic        ovf;
  logic        mis;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .SB_DEPTH    (4),
    .WR_LATENCY  (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .Memory_access     (acc),
    .Memory_RW         (rw),
    .Memory_sel        (sel),
    .Memory_Address    (addr),
    .Memory_Write_Data (wdata),
    .Memory_Read_Data  (rdata),
    .Memory_Ready      (ready),
    .SB_Empty          (sb_empty),
    .Overflow_Err      (ovf),
    .Misaligned_Err    (mis)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic r, input logic [3:0] s,
                       input logic [31:0] ad, input logic [31:0] wd);
    acc   = a;
    rw    = r;
    sel   = s;
    addr  = ad;
    wdata = wd;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, RW_LOAD, SEL_WORD, 32'h0, 32'h0);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    idle();
    while (sb_empty !== 1'b1 && n < budget) begin
      tick();
      idle();
      n++;
    end
    n_checks++;
    if (sb_empty !== 1'b1) $display("FAIL drain_timeout sb_empty=%b want 1", sb_empty);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    idle();
    n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (sb_empty !== 1'b1) $display("FAIL rst_empty got %b want 1", sb_empty); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf); else n_pass++;
    n_checks++; if (mis !== 1'b0) $display("FAIL rst_mis got %b want 0", mis); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else n_pass++;
    tick();
  endtask

  task automatic test_forward();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h10, 32'hDEADBEEF);
    n_checks++; if (rdata !== 32'h0) $display("FAIL store_rdata got %h want 0", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h10, 32'h0);
    n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL fwd_word got %h want deadbeef", rdata); else n_pass++;
    tick();
    wait_empty(20);
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h10, 32'h0);
    n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL arr_word got %h want deadbeef", rdata); else n_pass++;
    tick();
  endtask

  task automatic test_byte_merge();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h10, 32'h11223344);
    tick();
    drive(1'b1, RW_STORE, SEL_BYTE, 32'h13, 32'h00000055);
    tick();
    drive(1'b1, RW_LOAD, SEL_BYTE, 32'h13, 32'h0);
    n_checks++; if (rdata !== 32'h00000055) $display("FAIL byte_ld got %h want 00000055", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h10, 32'h0);
    n_checks++; if (rdata !== 32'h55223344) $display("FAIL merge_word got %h want 55223344", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_HALF, 32'h12, 32'h0);
    n_checks++; if (rdata !== 32'h00005522) $display("FAIL half_ld got %h want 00005522", rdata); else n_pass++;
    tick();
    wait_empty(20);
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h10, 32'h0);
    n_checks++; if (rdata !== 32'h55223344) $display("FAIL merge_arr got %h want 55223344", rdata); else n_pass++;
    tick();
  endtask

  task automatic test_youngest();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h20, 32'h01020304);
    tick();
    drive(1'b1, RW_STORE, SEL_BYTE, 32'h20, 32'h000000AA);
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h20, 32'h0);
    n_checks++; if (rdata !== 32'h010203AA) $display("FAIL youngest got %h want 010203aa", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_HALF, 32'h22, 32'h0);
    n_checks++; if (rdata !== 32'h00000102) $display("FAIL upper_half got %h want 00000102", rdata); else n_pass++;
    tick();
    wait_empty(20);
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h20, 32'h0);
    n_checks++; if (rdata !== 32'h010203AA) $display("FAIL youngest_arr got %h want 010203aa", rdata); else n_pass++;
    tick();
  endtask

  // Continuous stores overtake the drain: full at cycle 5 (accepted via same-cycle pop),
  // dropped at cycle 6; last commit at cycle 13, empty at cycle 14.
  task automatic test_full_overflow();
    logic [6:0] rdy_tab;
    rdy_tab = 7'b0011111;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) drive(1'b1, RW_STORE, SEL_WORD, 32'h100 + 32'(4 * k), 32'hC0DE0000 + 32'(k));
      else       drive(1'b1, RW_STORE, SEL_WORD, 32'h100, 32'hBAD0BAD0);
      n_checks++;
      if (ready !== rdy_tab[k]) $display("FAIL ready_c%0d got %b want %b", k, ready, rdy_tab[k]);
      else n_pass++;
      n_checks++;
      if (ovf !== 1'b0) $display("FAIL ovf_early_c%0d got %b want 0", k, ovf); else n_pass++;
      tick();
    end
    for (int c = 7; c < 15; c++) begin
      idle();
      n_checks++;
      if (ovf !== 1'b1) $display("FAIL ovf_sticky_c%0d got %b want 1", c, ovf); else n_pass++;
      n_checks++;
      if (sb_empty !== (c == 14)) $display("FAIL empty_c%0d got %b want %b", c, sb_empty, (c == 14));
      else n_pass++;
      tick();
    end
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h100, 32'h0);
    n_checks++; if (rdata !== 32'hC0DE0000) $display("FAIL dropped_st got %h want c0de0000", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h114, 32'h0);
    n_checks++; if (rdata !== 32'hC0DE0005) $display("FAIL last_acc got %h want c0de0005", rdata); else n_pass++;
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b1, RW_LOAD, SEL_HALF, 32'h21, 32'h0);
    n_checks++; if (rdata !== 32'h0) $display("FAIL mis_rdata got %h want 0", rdata); else n_pass++;
    tick();
    idle();
    n_checks++; if (mis !== 1'b1) $display("FAIL mis_ld_pulse got %b want 1", mis); else n_pass++;
    tick();
    idle();
    n_checks++; if (mis !== 1'b0) $display("FAIL mis_ld_clear got %b want 0", mis); else n_pass++;
    tick();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h22, 32'hFFFFFFFF);
    tick();
    idle();
    n_checks++; if (mis !== 1'b1) $display("FAIL mis_st_pulse got %b want 1", mis); else n_pass++;
    n_checks++; if (sb_empty !== 1'b1) $display("FAIL mis_st_push got %b want 1", sb_empty); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_hold got %b want 1", ovf); else n_pass++;
    tick();
    idle();
    n_checks++; if (mis !== 1'b0) $display("FAIL mis_st_clear got %b want 0", mis); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h30, 32'hA0A0A0A0); tick();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h34, 32'hB1B1B1B1); tick();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h38, 32'hC2C2C2C2); tick();
    wait_empty(30);
    drive(1'b1, RW_STORE, SEL_WORD, 32'h30, 32'h11111111); tick();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h34, 32'h22222222); tick();
    drive(1'b1, RW_STORE, SEL_WORD, 32'h38, 32'h33333333); tick();
    idle();
    n_checks++; if (sb_empty !== 1'b0) $display("FAIL pre_rst_busy got %b want 0", sb_empty); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_checks++; if (sb_empty !== 1'b1) $display("FAIL rst2_empty got %b want 1", sb_empty); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rst2_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst2_ovf got %b want 0", ovf); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h30, 32'h0);
    n_checks++; if (rdata !== 32'hA0A0A0A0) $display("FAIL rst_keep30 got %h want a0a0a0a0", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h34, 32'h0);
    n_checks++; if (rdata !== 32'hB1B1B1B1) $display("FAIL rst_keep34 got %h want b1b1b1b1", rdata); else n_pass++;
    tick();
    drive(1'b1, RW_LOAD, SEL_WORD, 32'h38, 32'h0);
    n_checks++; if (rdata !== 32'hC2C2C2C2) $display("FAIL rst_keep38 got %h want c2c2c2c2", rdata); else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    acc = 1'b0; rw = RW_LOAD; sel = SEL_WORD; addr = 32'h0; wdata = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_forward();
    test_byte_merge();
    test_youngest();
    test_full_overflow();
    test_misaligned();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
